// File: rtl/frame_gen_pkg.sv
// Shared types and constants for the frame pattern generator.
// Holds the pattern mode and FSM state encodings, the core ID, and the control-register bit positions.
package frame_gen_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } modeT;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } stateT;

    localparam logic [15:0] CORE_ID = 16'h0DEC;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_SOFT_RESET = 1;
    localparam int CTRL_MODE_LO    = 2;
    localparam int CTRL_MODE_HI    = 3;

    localparam int COUNTER_W = 13;

endpackage

// File: rtl/frame_gen_pixel_pattern.sv
// Combinational generator for one pixel of the selected test pattern.
// The pixel is computed from the pattern mode, the pixel column, the line number and the solid colour.
module frame_gen_pixel_pattern
    import frame_gen_pkg::*;
#(
    parameter int WIDTH       = 1920,
    parameter int NUM_PLANES  = 3,
    parameter int CHECK_SHIFT = 3
) (
    input  logic [1:0]              mode,
    input  logic [COUNTER_W-1:0]    c,
    input  logic [COUNTER_W-1:0]    row,
    input  logic [23:0]             solidColour,
    output logic [NUM_PLANES*8-1:0] pixel
);

    localparam logic [COUNTER_W-1:0] BAR_1 = COUNTER_W'(WIDTH / 4);
    localparam logic [COUNTER_W-1:0] BAR_2 = COUNTER_W'(WIDTH / 2);
    localparam logic [COUNTER_W-1:0] BAR_3 = COUNTER_W'((3 * WIDTH) / 4);

    modeT                 modeSel;
    logic [1:0]           barIdx;
    logic [COUNTER_W-1:0] cShift;
    logic [COUNTER_W-1:0] rShift;
    logic                 checkOn;
    logic                 unusedShiftBits;

    assign modeSel = modeT'(mode);
    assign cShift  = c >> CHECK_SHIFT;
    assign rShift  = row >> CHECK_SHIFT;
    assign checkOn = cShift[0] ^ rShift[0];
    assign unusedShiftBits = ^{cShift[COUNTER_W-1:1], rShift[COUNTER_W-1:1]};

    // Bar index 3 is the white quarter, which lights all of R, G and B.
    always_comb begin
        if (c < BAR_1)      barIdx = 2'd0;
        else if (c < BAR_2) barIdx = 2'd1;
        else if (c < BAR_3) barIdx = 2'd2;
        else                barIdx = 2'd3;
    end

    always_comb begin
        pixel = '0;
        for (int k = 0; k < NUM_PLANES; k++) begin
            case (modeSel)
                MODE_BARS:  pixel[k*8 +: 8] = ((k == int'(barIdx)) || (barIdx == 2'd3 && k < 3))
                                              ? 8'hFF : 8'h00;
                MODE_RAMP:  pixel[k*8 +: 8] = c[7:0];
                MODE_CHECK: pixel[k*8 +: 8] = checkOn ? 8'hFF : 8'h00;
                MODE_SOLID: pixel[k*8 +: 8] = 8'(solidColour >> (8 * k));
                default:    pixel[k*8 +: 8] = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/frame_pattern_generator.sv
// Test-pattern frame source: streams whole frames as ready/valid beats of PIXELS_PER_BEAT pixels,
// marking SOF (user) and end-of-line (last) and only starting or stopping on frame boundaries.
module frame_pattern_generator
    import frame_gen_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 1,
    parameter int NUM_PLANES      = 3,
    parameter int WIDTH           = 1920,
    parameter int HEIGHT          = 1080,
    parameter int CHECK_SHIFT     = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    output logic [PIXELS_PER_BEAT*NUM_PLANES*8-1:0] dataOut,
    output logic                                  dataOutValid,
    input  logic                                  dataOutReady,
    output logic                                  dataOutLast,
    output logic                                  dataOutUser,
    input  logic [31:0]                           controlRegister,
    input  logic [23:0]                           solidColour,
    output logic [15:0]                           frameCount,
    output logic [31:0]                           rowColCounter,
    output logic [15:0]                           CoreID
);

    localparam int PIX_W  = NUM_PLANES * 8;
    localparam int BEAT_W = PIXELS_PER_BEAT * PIX_W;

    localparam logic [COUNTER_W-1:0] COL_LAST = COUNTER_W'(WIDTH - PIXELS_PER_BEAT);
    localparam logic [COUNTER_W-1:0] ROW_LAST = COUNTER_W'(HEIGHT - 1);
    localparam logic [COUNTER_W-1:0] COL_STEP = COUNTER_W'(PIXELS_PER_BEAT);

    logic enable;
    logic softReset;
    logic xfer;
    logic unusedCtrlBits;

    stateT                stateQ, stateD;
    logic [COUNTER_W-1:0] rowQ, rowD;
    logic [COUNTER_W-1:0] colQ, colD;
    logic                 validQ, validD;
    logic                 lastQ, lastD;
    logic                 userQ, userD;
    logic [BEAT_W-1:0]    dataQ, dataD;
    logic [15:0]          frameCountQ, frameCountD;
    modeT                 modeQ, modeD;
    logic [23:0]          solidQ, solidD;
    logic                 loadBeat;
    logic                 clearBeat;
    logic                 startFrame;
    logic [BEAT_W-1:0]    beatPix;

    assign enable         = controlRegister[CTRL_ENABLE];
    assign softReset      = controlRegister[CTRL_SOFT_RESET];
    assign unusedCtrlBits = ^controlRegister[31:CTRL_MODE_HI+1];
    assign xfer           = validQ & dataOutReady;

    // Next-beat position, frame accounting and mode/colour latching at each SOF.
    always_comb begin
        stateD      = stateQ;
        rowD        = rowQ;
        colD        = colQ;
        validD      = validQ;
        frameCountD = frameCountQ;
        modeD       = modeQ;
        solidD      = solidQ;
        loadBeat    = 1'b0;
        clearBeat   = 1'b0;
        startFrame  = 1'b0;

        case (stateQ)
            IDLE: begin
                if (enable) begin
                    stateD     = ACTIVE;
                    rowD       = '0;
                    colD       = '0;
                    validD     = 1'b1;
                    startFrame = 1'b1;
                    loadBeat   = 1'b1;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    loadBeat = 1'b1;
                    if (colQ == COL_LAST) begin
                        colD = '0;
                        if (rowQ == ROW_LAST) begin
                            rowD        = '0;
                            frameCountD = frameCountQ + 16'd1;
                            if (enable) begin
                                startFrame = 1'b1;
                            end else begin
                                stateD    = IDLE;
                                validD    = 1'b0;
                                loadBeat  = 1'b0;
                                clearBeat = 1'b1;
                            end
                        end else begin
                            rowD = rowQ + 13'd1;
                        end
                    end else begin
                        colD = colQ + COL_STEP;
                    end
                end
            end
            default: ;
        endcase

        if (startFrame) begin
            modeD  = modeT'(controlRegister[CTRL_MODE_HI:CTRL_MODE_LO]);
            solidD = solidColour;
        end
    end

    for (genvar lane = 0; lane < PIXELS_PER_BEAT; lane++) begin : gLane
        frame_gen_pixel_pattern #(
            .WIDTH       (WIDTH),
            .NUM_PLANES  (NUM_PLANES),
            .CHECK_SHIFT (CHECK_SHIFT)
        ) uPixel (
            .mode        (modeD),
            .c           (colD + COUNTER_W'(lane)),
            .row         (rowD),
            .solidColour (solidD),
            .pixel       (beatPix[lane*PIX_W +: PIX_W])
        );
    end

    // Output beat is only reloaded on a new beat; under backpressure it holds.
    always_comb begin
        dataD = dataQ;
        lastD = lastQ;
        userD = userQ;
        if (loadBeat) begin
            dataD = beatPix;
            lastD = (colD == COL_LAST);
            userD = (rowD == '0) && (colD == '0);
        end else if (clearBeat) begin
            dataD = '0;
            lastD = 1'b0;
            userD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else if (softReset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rowQ        <= '0;
            colQ        <= '0;
            validQ      <= 1'b0;
            lastQ       <= 1'b0;
            userQ       <= 1'b0;
            dataQ       <= '0;
            frameCountQ <= '0;
            modeQ       <= MODE_BARS;
            solidQ      <= '0;
        end else if (softReset) begin
            rowQ        <= '0;
            colQ        <= '0;
            validQ      <= 1'b0;
            lastQ       <= 1'b0;
            userQ       <= 1'b0;
            dataQ       <= '0;
            frameCountQ <= '0;
            modeQ       <= MODE_BARS;
            solidQ      <= '0;
        end else begin
            rowQ        <= rowD;
            colQ        <= colD;
            validQ      <= validD;
            lastQ       <= lastD;
            userQ       <= userD;
            dataQ       <= dataD;
            frameCountQ <= frameCountD;
            modeQ       <= modeD;
            solidQ      <= solidD;
        end
    end

    assign dataOut       = dataQ;
    assign dataOutValid  = validQ;
    assign dataOutLast   = lastQ;
    assign dataOutUser   = userQ;
    assign frameCount    = frameCountQ;
    assign rowColCounter = {3'b000, rowQ, 3'b000, colQ};
    assign CoreID        = CORE_ID;

endmodule

// File: tb/tb_frame_pattern_generator.sv
// Bench for frame_pattern_generator on a small 8x4 frame, two pixels per beat.
// Expected beats are queued when stimulus is set up and compared as the stream delivers them.
module tb_frame_pattern_generator;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int PPB = 2;
    localparam int NP  = 3;
    localparam int CS  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] dataOut;
    logic        dataOutValid;
    logic        dataOutReady;
    logic        dataOutLast;
    logic        dataOutUser;
    logic [31:0] controlRegister;
    logic [23:0] solidColour;
    logic [15:0] frameCount;
    logic [31:0] rowColCounter;
    logic [15:0] CoreID;

    always #5 clk = ~clk;

    frame_pattern_generator #(
        .PIXELS_PER_BEAT (PPB),
        .NUM_PLANES      (NP),
        .WIDTH           (W),
        .HEIGHT          (H),
        .CHECK_SHIFT     (CS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dataOut         (dataOut),
        .dataOutValid    (dataOutValid),
        .dataOutReady    (dataOutReady),
        .dataOutLast     (dataOutLast),
        .dataOutUser     (dataOutUser),
        .controlRegister (controlRegister),
        .solidColour     (solidColour),
        .frameCount      (frameCount),
        .rowColCounter   (rowColCounter),
        .CoreID          (CoreID)
    );

    typedef struct packed {
        logic [47:0] data;
        logic        last;
        logic        user;
        logic [31:0] rc;
    } beatT;

    beatT sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   popCount   = 0;
    int   readyMode  = 1;
    bit   checkStall = 1'b1;
    bit   prevStall  = 1'b0;
    beatT held;

    function automatic logic [23:0] modelPix(int mode, int c, int row, logic [23:0] solid);
        logic [7:0] b;
        b = 8'(c);
        case (mode)
            0: begin
                if (c < 2)      return 24'h0000FF;
                else if (c < 4) return 24'h00FF00;
                else if (c < 6) return 24'hFF0000;
                else            return 24'hFFFFFF;
            end
            1: return {b, b, b};
            2: return ((((c >> 1) ^ (row >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return solid;
        endcase
    endfunction

    task automatic pushFrame(int mode, logic [23:0] solid);
        beatT b;
        for (int r = 0; r < H; r++) begin
            for (int col = 0; col < W; col += PPB) begin
                b.data = {modelPix(mode, col + 1, r, solid), modelPix(mode, col, r, solid)};
                b.last = (col == W - PPB);
                b.user = (r == 0) && (col == 0);
                b.rc   = {3'b000, 13'(r), 3'b000, 13'(col)};
                sb.push_back(b);
            end
        end
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitPops(int n, int budget);
        int target;
        int k;
        target = popCount + n;
        k = 0;
        while (popCount < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
            case (readyMode)
                0:       dataOutReady = 1'b0;
                1:       dataOutReady = 1'b1;
                default: dataOutReady = 1'($urandom_range(0, 1));
            endcase
        end
        check("wait_pops", 64'(popCount >= target), 64'd1);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor: scoreboard compare on every transfer, hold check on every stall.
    always @(negedge clk) begin
        beatT obs;
        beatT exp;
        obs.data = dataOut;
        obs.last = dataOutLast;
        obs.user = dataOutUser;
        obs.rc   = rowColCounter;
        if (checkStall && prevStall) begin
            checks++;
            assert ({dataOutValid, obs} === {1'b1, held}) else begin
                failures++;
                $error("FAIL stall_hold observed=%0h expected=%0h", {dataOutValid, obs}, {1'b1, held});
            end
        end
        if (dataOutValid && dataOutReady) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_beat observed=%0h expected=none", obs);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                assert (obs === exp) else begin
                    failures++;
                    $error("FAIL beat_%0d observed=%0h expected=%0h", popCount, obs, exp);
                end
            end
            popCount++;
        end
        prevStall = dataOutValid && !dataOutReady;
        held      = obs;
    end

    initial begin
        reset           = 1'b0;
        controlRegister = 32'h0;
        solidColour     = 24'h0;
        dataOutReady    = 1'b0;
        #12;
        check("reset_valid", 64'(dataOutValid), 64'd0);
        check("reset_data", 64'(dataOut), 64'd0);
        check("reset_last_user", 64'({dataOutLast, dataOutUser}), 64'd0);
        check("reset_frame_count", 64'(frameCount), 64'd0);
        check("reset_rowcol", 64'(rowColCounter), 64'd0);
        check("core_id", 64'(CoreID), 64'h0DEC);
        stepCycle();
        reset = 1'b1;
        stepCycle();
        check("idle_valid", 64'(dataOutValid), 64'd0);

        // Colour bars with ready held high, two frames back to back.
        pushFrame(0, 24'h0);
        pushFrame(0, 24'h0);
        readyMode       = 1;
        dataOutReady    = 1'b1;
        controlRegister = 32'h1;
        waitPops(16, 100);
        check("bars_frame_count_1", 64'(frameCount), 64'd1);
        waitPops(4, 50);
        controlRegister = 32'h0;
        waitPops(12, 50);
        check("bars_idle_valid", 64'(dataOutValid), 64'd0);
        check("bars_frame_count_2", 64'(frameCount), 64'd2);
        check("bars_sb_empty", 64'(sb.size()), 64'd0);

        // Ramp under random backpressure.
        pushFrame(1, 24'h0);
        readyMode       = 2;
        controlRegister = 32'h1 | (32'd1 << 2);
        waitPops(3, 100);
        controlRegister = 32'h0;
        waitPops(13, 400);
        check("ramp_idle_valid", 64'(dataOutValid), 64'd0);
        check("ramp_frame_count", 64'(frameCount), 64'd3);

        // Enable dropped at beat 5 of the first frame after reset.
        reset = 1'b0;
        stepCycle();
        reset = 1'b1;
        pushFrame(0, 24'h0);
        readyMode       = 1;
        dataOutReady    = 1'b1;
        controlRegister = 32'h1;
        waitPops(5, 50);
        controlRegister = 32'h0;
        waitPops(11, 50);
        check("drop_idle_valid", 64'(dataOutValid), 64'd0);
        check("drop_frame_count", 64'(frameCount), 64'd1);
        stepCycle();
        check("drop_stays_idle", 64'(dataOutValid), 64'd0);

        // Mode and colour changes mid-frame take effect only at the next SOF.
        solidColour     = 24'hABCDEF;
        pushFrame(2, 24'h0);
        pushFrame(3, 24'h123456);
        controlRegister = 32'h1 | (32'd2 << 2);
        waitPops(5, 50);
        controlRegister = 32'h1 | (32'd3 << 2);
        solidColour     = 24'h123456;
        waitPops(15, 50);
        controlRegister = 32'h0;
        solidColour     = 24'h000000;
        waitPops(12, 50);
        check("latch_idle_valid", 64'(dataOutValid), 64'd0);
        check("latch_frame_count", 64'(frameCount), 64'd3);

        // Soft reset while beat 9 is stalled.
        pushFrame(0, 24'h0);
        controlRegister = 32'h1;
        waitPops(9, 50);
        dataOutReady = 1'b0;
        readyMode    = 0;
        stepCycle();
        check("stall_beat9_valid", 64'(dataOutValid), 64'd1);
        check("stall_beat9_rowcol", 64'(rowColCounter), 64'h0002_0002);
        checkStall      = 1'b0;
        controlRegister = 32'h3;
        stepCycle();
        check("soft_valid", 64'(dataOutValid), 64'd0);
        check("soft_rowcol", 64'(rowColCounter), 64'd0);
        check("soft_frame_count", 64'(frameCount), 64'd0);
        sb.delete();
        pushFrame(0, 24'h0);
        stepCycle();
        check("soft_hold_valid", 64'(dataOutValid), 64'd0);
        controlRegister = 32'h1;
        readyMode       = 1;
        dataOutReady    = 1'b1;
        checkStall      = 1'b1;
        stepCycle();
        check("soft_sof_valid_user", 64'({dataOutValid, dataOutUser}), 64'd3);
        check("soft_sof_rowcol", 64'(rowColCounter), 64'd0);

        // Asynchronous reset while beat 9 is stalled.
        waitPops(9, 50);
        dataOutReady = 1'b0;
        readyMode    = 0;
        stepCycle();
        checkStall = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", 64'(dataOutValid), 64'd0);
        check("async_rowcol", 64'(rowColCounter), 64'd0);
        check("async_data", 64'(dataOut), 64'd0);
        sb.delete();
        pushFrame(0, 24'h0);
        stepCycle();
        reset        = 1'b1;
        dataOutReady = 1'b1;
        readyMode    = 1;
        checkStall   = 1'b1;
        stepCycle();
        check("async_sof_valid_user", 64'({dataOutValid, dataOutUser}), 64'd3);
        check("async_sof_rowcol", 64'(rowColCounter), 64'd0);
        waitPops(2, 20);
        controlRegister = 32'h0;
        waitPops(14, 50);
        check("async_idle_valid", 64'(dataOutValid), 64'd0);
        check("async_frame_count", 64'(frameCount), 64'd1);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
